// File: rtl/gridworld_agent_stepper_if.sv
// Agent-stepper bundle: Q-table read port, core handshake and episode status.
// Latency: n/a (signal bundle only).
// Backpressure: core_start/core_done handshake; the stepper stalls until core_done.
interface gridworld_agent_stepper_if;
    logic               episode_start;
    logic [4:0]         q_rd_row;
    logic [4:0]         q_rd_col;
    logic [1:0]         q_rd_action;
    logic signed [15:0] q_rd_data;
    logic               core_start;
    logic [4:0]         s_row;
    logic [4:0]         s_col;
    logic [4:0]         s_prime_row;
    logic [4:0]         s_prime_col;
    logic [1:0]         action;
    logic [15:0]        reward;
    logic               core_done;
    logic               busy;
    logic               episode_done;
    logic               reached_goal;
    logic [7:0]         step_count;
    logic [15:0]        lfsr_state;

    // Stepper side
    modport master (
        input  episode_start, q_rd_data, core_done,
        output q_rd_row, q_rd_col, q_rd_action, core_start,
               s_row, s_col, s_prime_row, s_prime_col, action, reward,
               busy, episode_done, reached_goal, step_count, lfsr_state
    );

    // Environment side (Q-table memory, q_learning_core, episode control)
    modport slave (
        output episode_start, q_rd_data, core_done,
        input  q_rd_row, q_rd_col, q_rd_action, core_start,
               s_row, s_col, s_prime_row, s_prime_col, action, reward,
               busy, episode_done, reached_goal, step_count, lfsr_state
    );
endinterface

// File: rtl/gridworld_agent_stepper.sv
// Gridworld agent stepper: reads 4 Q-values, picks an epsilon-greedy action, issues one core step.
// Latency: 6 cycles from step start (READQ entry, inclusive) to the core_start pulse.
// Backpressure: holds in WAIT with outputs frozen until core_done; no timeout.
module gridworld_agent_stepper #(
    parameter int          GRID_ROWS   = 8,
    parameter int          GRID_COLS   = 8,
    parameter int          START_ROW   = 0,
    parameter int          START_COL   = 0,
    parameter int          GOAL_ROW    = 7,
    parameter int          GOAL_COL    = 7,
    parameter int          REWARD_STEP = -4096,
    parameter int          REWARD_WALL = -20480,
    parameter int          REWARD_GOAL = 40960,
    parameter int          EPS_THRESH  = 26,
    parameter int          MAX_STEPS   = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    gridworld_agent_stepper_if.master   bus
);
    typedef enum logic [2:0] {IDLE, READQ, SELECT, ISSUE, WAIT, ADVANCE, FINISH} state_t;

    localparam logic [4:0]  START_R = 5'(START_ROW);
    localparam logic [4:0]  START_C = 5'(START_COL);
    localparam logic [4:0]  GOAL_R  = 5'(GOAL_ROW);
    localparam logic [4:0]  GOAL_C  = 5'(GOAL_COL);
    localparam logic [4:0]  ROW_MAX = 5'(GRID_ROWS - 1);
    localparam logic [4:0]  COL_MAX = 5'(GRID_COLS - 1);
    // The goal reward exceeds the Q4.12 range; its low 16 bits are forwarded as-is.
    localparam logic [15:0] R_STEP  = 16'(REWARD_STEP);
    localparam logic [15:0] R_WALL  = 16'(REWARD_WALL);
    localparam logic [15:0] R_GOAL  = 16'(REWARD_GOAL);
    localparam logic [8:0]  EPS_T   = 9'(EPS_THRESH);
    localparam logic [7:0]  MAX_T   = 8'(MAX_STEPS);

    state_t             state, state_nxt;
    logic [1:0]         rd_idx;
    logic signed [15:0] q_cap [3];
    logic signed [15:0] q_all [4];
    logic [4:0]         s_row_q, s_col_q, sp_row_q, sp_col_q;
    logic [1:0]         action_q;
    logic [15:0]        reward_q;
    logic [7:0]         step_q, step_inc;
    logic               goal_q, at_goal;
    logic [15:0]        lfsr_q, lfsr_nxt;
    logic [1:0]         best, act_sel;
    logic               explore, hit_wall;
    logic [4:0]         nxt_row, nxt_col;
    logic [15:0]        rew_sel;

    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign step_inc = step_q + 8'd1;
    assign at_goal  = (sp_row_q == GOAL_R) && (sp_col_q == GOAL_C);

    // Epsilon-greedy choice; Q[3] is still on the read bus during SELECT
    always_comb begin
        q_all[0] = q_cap[0];
        q_all[1] = q_cap[1];
        q_all[2] = q_cap[2];
        q_all[3] = bus.q_rd_data;
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (q_all[i] > q_all[best]) best = 2'(i);
        end
        explore = ({1'b0, lfsr_nxt[7:0]} < EPS_T);
        act_sel = explore ? lfsr_nxt[9:8] : best;
    end

    // Next cell and reward for the chosen action; walls win over the goal
    always_comb begin
        nxt_row  = s_row_q;
        nxt_col  = s_col_q;
        hit_wall = 1'b0;
        case (act_sel)
            2'd0:    if (s_row_q == 5'd0)    hit_wall = 1'b1; else nxt_row = s_row_q - 5'd1;
            2'd1:    if (s_row_q == ROW_MAX) hit_wall = 1'b1; else nxt_row = s_row_q + 5'd1;
            2'd2:    if (s_col_q == 5'd0)    hit_wall = 1'b1; else nxt_col = s_col_q - 5'd1;
            default: if (s_col_q == COL_MAX) hit_wall = 1'b1; else nxt_col = s_col_q + 5'd1;
        endcase
        if (hit_wall)                                  rew_sel = R_WALL;
        else if (nxt_row == GOAL_R && nxt_col == GOAL_C) rew_sel = R_GOAL;
        else                                           rew_sel = R_STEP;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.episode_start) state_nxt = READQ;
            READQ:   if (rd_idx == 2'd3)    state_nxt = SELECT;
            SELECT:  state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.core_done)     state_nxt = ADVANCE;
            ADVANCE: state_nxt = (at_goal || step_inc == MAX_T) ? FINISH : READQ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.core_start   = (state == ISSUE);
        bus.busy         = (state != IDLE);
        bus.episode_done = (state == FINISH);
        bus.q_rd_row     = (state == READQ) ? s_row_q : 5'd0;
        bus.q_rd_col     = (state == READQ) ? s_col_q : 5'd0;
        bus.q_rd_action  = (state == READQ) ? rd_idx  : 2'd0;
    end

    // Episode datapath: Q capture, step selection, position and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx   <= 2'd0;
            for (int i = 0; i < 3; i++) q_cap[i] <= '0;
            s_row_q  <= START_R;
            s_col_q  <= START_C;
            sp_row_q <= 5'd0;
            sp_col_q <= 5'd0;
            action_q <= 2'd0;
            reward_q <= 16'd0;
            step_q   <= 8'd0;
            goal_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.episode_start) begin
                        s_row_q <= START_R;
                        s_col_q <= START_C;
                        step_q  <= 8'd0;
                        goal_q  <= 1'b0;
                    end
                end
                READQ: begin
                    rd_idx <= rd_idx + 2'd1;
                    if (rd_idx != 2'd0) q_cap[rd_idx - 2'd1] <= bus.q_rd_data;
                end
                SELECT: begin
                    lfsr_q   <= lfsr_nxt;
                    action_q <= act_sel;
                    sp_row_q <= nxt_row;
                    sp_col_q <= nxt_col;
                    reward_q <= rew_sel;
                end
                ADVANCE: begin
                    s_row_q <= sp_row_q;
                    s_col_q <= sp_col_q;
                    step_q  <= step_inc;
                    goal_q  <= at_goal;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_row        = s_row_q;
    assign bus.s_col        = s_col_q;
    assign bus.s_prime_row  = sp_row_q;
    assign bus.s_prime_col  = sp_col_q;
    assign bus.action       = action_q;
    assign bus.reward       = reward_q;
    assign bus.reached_goal = goal_q;
    assign bus.step_count   = step_q;
    assign bus.lfsr_state   = lfsr_q;
endmodule

// File: tb/tb_gridworld_agent_stepper.sv
// Directed bench for gridworld_agent_stepper: greedy walk table, wall/goal/limit episodes, reset, exploration.
// Latency: checks the 6-cycle step start to core_start distance.
// Backpressure: holds core_done low for up to 50 cycles and injects spurious pulses.
`timescale 1ns/1ps
module tb_gridworld_agent_stepper;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gridworld_agent_stepper_if a_if ();
    gridworld_agent_stepper_if b_if ();
    gridworld_agent_stepper_if c_if ();
    gridworld_agent_stepper_if d_if ();

    gridworld_agent_stepper #(.EPS_THRESH(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    gridworld_agent_stepper #(.EPS_THRESH(0), .START_ROW(7), .START_COL(6)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
    gridworld_agent_stepper #(.EPS_THRESH(0), .START_ROW(3), .START_COL(3), .MAX_STEPS(4)) dut_c (.clk(clk), .rst(rst), .bus(c_if));
    gridworld_agent_stepper dut_d (.clk(clk), .rst(rst), .bus(d_if));

    // Q-table models: one-cycle read latency
    logic signed [15:0] qa_tab [4];
    logic [4:0]         qa_row, qa_col;
    always @(posedge clk) begin
        if (a_if.q_rd_row == qa_row && a_if.q_rd_col == qa_col) a_if.q_rd_data <= qa_tab[a_if.q_rd_action];
        else                                                    a_if.q_rd_data <= 16'sh7fff;
    end
    always @(posedge clk) b_if.q_rd_data <= (b_if.q_rd_action == 2'd3) ? 16'sd100 : 16'sd0;
    assign c_if.q_rd_data = 16'sd0;
    assign d_if.q_rd_data = 16'sd0;

    typedef struct {
        logic signed [15:0] q0, q1, q2, q3;
        logic [1:0]         act;
        logic [4:0]         sp_row, sp_col;
        logic [15:0]        rew;
        int                 wait_len;
        bit                 spur;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    logic [4:0]  cur_r, cur_c;
    logic [15:0] exp_l;
    logic [4:0]  snap_spr, snap_spc;
    logic [1:0]  snap_act;
    logic [15:0] snap_rew;
    int          t0, n, seen, stable, pulses, done_seen, steps, expl, act_bad, l_bad, guard;
    logic        prev_cs, prev_ed, rg;
    logic [7:0]  sc;
    logic [15:0] last_rew;
    logic [1:0]  exp_act;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{-16'sd4096, 16'sd8192, 16'sd2048, 16'sd8192, 2'd1, 5'd1, 5'd0, 16'hF000, 2, 1'b0};
        vt[1] = '{16'sd4096, 16'sd0, 16'sd0, 16'sd0, 2'd0, 5'd0, 5'd0, 16'hF000, 50, 1'b1};
        vt[2] = '{16'sd100, 16'sd0, 16'sd0, 16'sd0, 2'd0, 5'd0, 5'd0, 16'hB000, 1, 1'b0};
        vt[3] = '{16'sd0, 16'sd0, 16'sd5, 16'sd0, 2'd2, 5'd0, 5'd0, 16'hB000, 3, 1'b0};
        vt[4] = '{-16'sd8, -16'sd100, 16'sd5, -16'sd3, 2'd2, 5'd0, 5'd0, 16'hB000, 1, 1'b0};
        vt[5] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 2'd0, 5'd0, 5'd0, 16'hB000, 1, 1'b0};
        vt[6] = '{16'sd0, 16'sd0, 16'sd0, 16'sd1, 2'd3, 5'd0, 5'd1, 16'hF000, 1, 1'b1};
        vt[7] = '{16'sd0, 16'sd32767, 16'sd0, 16'sd0, 2'd1, 5'd1, 5'd1, 16'hF000, 4, 1'b0};
        vt[8] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32767, 2'd3, 5'd1, 5'd2, 16'hF000, 1, 1'b0};

        rst = 1'b1;
        a_if.episode_start = 1'b0; a_if.core_done = 1'b0;
        b_if.episode_start = 1'b0; b_if.core_done = 1'b0;
        c_if.episode_start = 1'b0; c_if.core_done = 1'b0;
        d_if.episode_start = 1'b0; d_if.core_done = 1'b0;
        qa_row = 5'd0; qa_col = 5'd0;
        for (int k = 0; k < 4; k++) qa_tab[k] = 16'sd0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_busy", a_if.busy, 1'b0);
        chk("rst_core_start", a_if.core_start, 1'b0);
        chk("rst_episode_done", a_if.episode_done, 1'b0);
        chk("rst_s", {a_if.s_row, a_if.s_col}, 10'd0);
        chk("rst_lfsr", a_if.lfsr_state, 16'hACE1);
        chk("rst_misc", {a_if.step_count, a_if.reward, a_if.action, a_if.reached_goal}, 27'd0);
        chk("rst_s_b", {b_if.s_row, b_if.s_col}, {5'd7, 5'd6});
        rst = 1'b0;
        @(negedge clk);

        // Table-driven greedy walk on instance A
        cur_r = 5'd0; cur_c = 5'd0; exp_l = 16'hACE1;
        for (int i = 0; i < 9; i++) begin
            qa_tab[0] = vt[i].q0; qa_tab[1] = vt[i].q1; qa_tab[2] = vt[i].q2; qa_tab[3] = vt[i].q3;
            qa_row = cur_r; qa_col = cur_c;
            if (i == 0) begin
                a_if.episode_start = 1'b1;
                t0 = cyc;
            end
            if (vt[i].spur) begin
                a_if.core_done = 1'b1;
                a_if.episode_start = 1'b1;
            end
            n = 0; seen = 0;
            while (n < 20 && seen == 0) begin
                @(negedge clk);
                a_if.core_done = 1'b0; a_if.episode_start = 1'b0;
                n++;
                if (a_if.core_start) seen = 1;
            end
            chk($sformatf("v%0d_core_start_seen", i), seen, 1);
            if (i == 0) chk("v0_latency", cyc - t0, 6);
            chk($sformatf("v%0d_action", i), a_if.action, vt[i].act);
            chk($sformatf("v%0d_s_prime", i), {a_if.s_prime_row, a_if.s_prime_col}, {vt[i].sp_row, vt[i].sp_col});
            chk($sformatf("v%0d_reward", i), a_if.reward, vt[i].rew);
            chk($sformatf("v%0d_s", i), {a_if.s_row, a_if.s_col}, {cur_r, cur_c});
            snap_spr = vt[i].sp_row; snap_spc = vt[i].sp_col; snap_act = vt[i].act; snap_rew = vt[i].rew;
            stable = 1;
            for (int w = 0; w < vt[i].wait_len; w++) begin
                @(negedge clk);
                if (a_if.core_start !== 1'b0 || a_if.busy !== 1'b1 || a_if.action !== snap_act ||
                    a_if.reward !== snap_rew || a_if.s_prime_row !== snap_spr || a_if.s_prime_col !== snap_spc ||
                    a_if.s_row !== cur_r || a_if.s_col !== cur_c) stable = 0;
            end
            chk($sformatf("v%0d_wait_stable", i), stable, 1);
            a_if.core_done = 1'b1;
            @(negedge clk);
            a_if.core_done = 1'b0;
            chk($sformatf("v%0d_hold_after_done", i), {a_if.s_row, a_if.s_col, a_if.action}, {cur_r, cur_c, snap_act});
            @(negedge clk);
            exp_l = lfsr_adv(exp_l);
            cur_r = vt[i].sp_row; cur_c = vt[i].sp_col;
            chk($sformatf("v%0d_s_after", i), {a_if.s_row, a_if.s_col}, {cur_r, cur_c});
            chk($sformatf("v%0d_step_count", i), a_if.step_count, i + 1);
            chk($sformatf("v%0d_lfsr", i), a_if.lfsr_state, exp_l);
        end

        // Reset mid-WAIT
        for (int k = 0; k < 4; k++) qa_tab[k] = 16'sd0;
        qa_row = cur_r; qa_col = cur_c;
        n = 0; seen = 0;
        while (n < 20 && seen == 0) begin
            @(negedge clk); n++;
            if (a_if.core_start) seen = 1;
        end
        chk("rstw_core_start_seen", seen, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_busy", a_if.busy, 1'b0);
        chk("rstw_core_start", a_if.core_start, 1'b0);
        chk("rstw_s", {a_if.s_row, a_if.s_col}, 10'd0);
        chk("rstw_lfsr", a_if.lfsr_state, 16'hACE1);
        chk("rstw_step_count", a_if.step_count, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stable = 1;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            a_if.core_done = (w == 5);
            if (a_if.episode_done !== 1'b0 || a_if.core_start !== 1'b0 || a_if.busy !== 1'b0) stable = 0;
        end
        a_if.core_done = 1'b0;
        chk("rstw_quiet_after", stable, 1);

        // Goal episode on instance B
        b_if.episode_start = 1'b1;
        n = 0; seen = 0;
        while (n < 20 && seen == 0) begin
            @(negedge clk); b_if.episode_start = 1'b0; n++;
            if (b_if.core_start) seen = 1;
        end
        chk("goal_core_start_seen", seen, 1);
        chk("goal_move", {b_if.s_row, b_if.s_col, b_if.s_prime_row, b_if.s_prime_col, b_if.action},
            {5'd7, 5'd6, 5'd7, 5'd7, 2'd3});
        chk("goal_reward", b_if.reward, 16'hA000);
        @(negedge clk);
        b_if.core_done = 1'b1;
        n = 0; seen = 0;
        while (n < 10 && seen == 0) begin
            @(negedge clk); b_if.core_done = 1'b0; n++;
            if (b_if.episode_done) seen = 1;
        end
        chk("goal_episode_done", seen, 1);
        chk("goal_reached", b_if.reached_goal, 1'b1);
        chk("goal_step_count", b_if.step_count, 8'd1);
        @(negedge clk);
        chk("goal_done_pulse_idle", {b_if.episode_done, b_if.busy}, 2'b00);
        chk("goal_hold", {b_if.reached_goal, b_if.step_count}, {1'b1, 8'd1});

        // Step-limit episode on instance C: always up from (3,3)
        c_if.episode_start = 1'b1;
        pulses = 0; done_seen = 0; prev_cs = 1'b0; rg = 1'b1; sc = 8'd0; last_rew = 16'd0;
        for (int k = 0; k < 200 && done_seen == 0; k++) begin
            @(negedge clk);
            c_if.episode_start = 1'b0;
            c_if.core_done = prev_cs;
            prev_cs = c_if.core_start;
            if (c_if.core_start) begin pulses++; last_rew = c_if.reward; end
            if (c_if.episode_done) begin done_seen = 1; rg = c_if.reached_goal; sc = c_if.step_count; end
        end
        c_if.core_done = 1'b0;
        chk("limit_episode_done", done_seen, 1);
        chk("limit_pulses", pulses, 4);
        chk("limit_reached_goal", rg, 1'b0);
        chk("limit_step_count", sc, 8'd4);
        chk("limit_final_cell", {c_if.s_row, c_if.s_col}, {5'd0, 5'd3});
        chk("limit_last_reward", last_rew, 16'hB000);

        // Exploration rate on instance D (default threshold 26)
        @(negedge clk);
        d_if.episode_start = 1'b1;
        steps = 0; expl = 0; act_bad = 0; l_bad = 0; guard = 0;
        prev_cs = 1'b0; prev_ed = 1'b0; exp_l = 16'hACE1;
        while (steps < 1000 && guard < 20000) begin
            @(negedge clk);
            guard++;
            d_if.episode_start = prev_ed;
            d_if.core_done = prev_cs;
            prev_cs = d_if.core_start;
            prev_ed = d_if.episode_done;
            if (d_if.core_start) begin
                exp_l = lfsr_adv(exp_l);
                if (exp_l[7:0] < 8'd26) begin expl++; exp_act = exp_l[9:8]; end
                else exp_act = 2'd0;
                if (d_if.action !== exp_act) act_bad++;
                if (d_if.lfsr_state !== exp_l) l_bad++;
                steps++;
            end
        end
        d_if.episode_start = 1'b0;
        d_if.core_done = 1'b0;
        chk("explore_steps", steps, 1000);
        chk("explore_action_errors", act_bad, 0);
        chk("explore_lfsr_errors", l_bad, 0);
        chk("explore_rate_7_13pct", (expl >= 70 && expl <= 130), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gridworld_agent_stepper.md
Name: gridworld_agent_stepper

Overview:
Upstream driver for q_learning_core. Walks a single agent through a gridworld episode. Each step it:
- reads the four Q-values for the current cell,
- picks an action epsilon-greedily using an internal LFSR,
- computes the next cell and the Q4.12 reward,
- pulses start into the core, then waits for done before the next step.

The episode ends at the goal cell or after MAX_STEPS steps.

Parameters:
GRID_ROWS, 8, number of grid rows (max 32)
GRID_COLS, 8, number of grid columns (max 32)
START_ROW / START_COL, 0 / 0, agent cell at each episode start
GOAL_ROW / GOAL_COL, 7 / 7, terminal cell
REWARD_STEP, -4096, Q4.12 reward (-1.0) for a legal non-goal move
REWARD_WALL, -20480, Q4.12 reward (-5.0) for a move into a wall
REWARD_GOAL, 40960, Q4.12 reward (+10.0) for a move onto the goal
EPS_THRESH, 26, explore when lfsr[7:0] < EPS_THRESH (about 10%)
MAX_STEPS, 64, step limit per episode
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
episode_start  input  1  one-cycle pulse; starts an episode when idle
q_rd_row  output  5  Q-table read row
q_rd_col  output  5  Q-table read column
q_rd_action  output  2  Q-table read action
q_rd_data  input  16  signed Q4.12; valid 1 cycle after address
core_start  output  1  one-cycle start pulse to q_learning_core
s_row, s_col  output  5 each  current state to core
s_prime_row, s_prime_col  output  5 each  next state to core
action  output  2  chosen action (0 up, 1 down, 2 left, 3 right)
reward  output  16  signed Q4.12 reward
core_done  input  1  completion from q_learning_core
busy  output  1  high in every state except IDLE
episode_done  output  1  one-cycle pulse when an episode ends
reached_goal  output  1  valid with episode_done: 1 = goal, 0 = step limit
step_count  output  8  steps completed in the current episode
lfsr_state  output  16  current LFSR value (for debug)

Behaviour:
- Reset values: all outputs 0, except s_row/s_col = START_ROW/START_COL, lfsr_state = LFSR_SEED. FSM in IDLE.
- Reset asserted mid-episode aborts immediately; no pulses are emitted afterwards.
- FSM states: IDLE, READQ, SELECT, ISSUE, WAIT, ADVANCE, FINISH.
- IDLE: on episode_start, load position = (START_ROW, START_COL), step_count = 0, go to READQ.
  - episode_start is ignored in every other state.
- READQ: 4 cycles. Cycle k drives q_rd_action = k with q_rd_row/q_rd_col = current cell.
  - q_rd_data is captured 1 cycle later, so the last value lands in the first SELECT cycle.
  - SELECT is therefore entered after READQ with that final capture.
- SELECT (1 cycle):
  - Advance the LFSR once: x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0.
  - Use the post-advance value.
  - If lfsr[7:0] < EPS_THRESH, action = lfsr[9:8] (explore).
  - Otherwise action = argmax of the 4 signed Q-values; strict greater-than, so ties go to the lowest index.
- Next-cell computation (registered in SELECT):
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - If the move leaves 0..GRID_ROWS-1 or 0..GRID_COLS-1, s_prime = s and reward = REWARD_WALL.
  - Otherwise, if s_prime == goal, reward = REWARD_GOAL.
  - Otherwise reward = REWARD_STEP.
  - Wall check takes priority over goal check.
- ISSUE: core_start = 1 for exactly 1 cycle. s/s_prime/action/reward are stable from ISSUE until the cycle after core_done.
- WAIT: hold until core_done == 1. core_done in any other state is ignored. No timeout.
- ADVANCE: s <= s_prime; step_count += 1.
  - If the new cell == goal: reached_goal = 1, go to FINISH.
  - Else if step_count == MAX_STEPS: reached_goal = 0, go to FINISH.
  - Else go to READQ.
- FINISH: episode_done = 1 for 1 cycle, go to IDLE.
  - reached_goal and step_count hold until the next episode_start.
- Step latency from READQ entry to core_start: 6 cycles.
- Starting on the goal cell is still a normal episode; it ends only after a step lands on the goal.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT -> busy=0, core_start=0, s=(0,0), lfsr_state=16'hACE1 immediately; no later episode_done.
- Greedy pick: EPS_THRESH=0, Q model returns {-1.0, 2.0, 0.5, 2.0} for cell (0,0) -> action=1, s_prime=(1,0), reward=-4096; core_start one cycle, 6 cycles after episode_start+1.
- Wall: EPS_THRESH=0, Q at (0,0) favours action 0 -> s_prime=(0,0), reward=-20480; after core_done, s stays (0,0) and step_count=1.
- Goal: START=(7,6), Q favours right -> s_prime=(7,7), reward=40960; episode_done pulse with reached_goal=1, step_count=1.
- Step limit: MAX_STEPS=4, all Q=0 and EPS_THRESH=0 (always up from (3,3)) -> 4 core_start pulses, episode_done with reached_goal=0, step_count=4.
- Handshake robustness: hold core_done low for 50 cycles; send spurious core_done in READQ and episode_start while busy -> outputs stable in WAIT, spurious pulses ignored; exploration rate over 1000 steps with EPS_THRESH=26 falls within 7-13%.
